// File: rtl/sb_tx_arbiter_if.sv
// sb_tx_arbiter_if: N requester TX streams plus the single shared output stream
interface sb_tx_arbiter_if #(parameter int N = 4, parameter int DW = 256);
  logic [N*DW-1:0] in_data;
  logic [N*32-1:0] in_dest;
  logic [N-1:0]    in_last;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [DW-1:0]   out_data;
  logic [31:0]     out_dest;
  logic            out_last;
  logic            out_valid;
  logic            out_ready;
  modport master (
    output in_data, in_dest, in_last, in_valid, out_ready,
    input  in_ready, out_data, out_dest, out_last, out_valid
  );
  modport slave (
    input  in_data, in_dest, in_last, in_valid, out_ready,
    output in_ready, out_data, out_dest, out_last, out_valid
  );
endinterface

// File: rtl/sb_tx_arbiter.sv
// sb_tx_arbiter: packet-granular round-robin arbiter feeding one registered TX stream
module sb_tx_arbiter #(
  parameter int N  = 4,
  parameter int DW = 256
) (
  input  logic          clk,
  input  logic          nreset,
  sb_tx_arbiter_if.slave bus,
  output logic [N-1:0]  grant,
  output logic [31:0]   pkt_count
);
  localparam int PW = $clog2(N);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d, owner_q, owner_d, sel, cur;
  logic [N-1:0]    grant_q, grant_d;
  logic [31:0]     pkt_count_q, pkt_count_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic [31:0]     out_dest_q, out_dest_d;
  logic            out_last_q, out_last_d, out_valid_q, out_valid_d;
  logic            found, adv, acc, cur_last;
  function automatic logic [PW-1:0] wrap(int j);
    return PW'(j >= N ? j - N : j);
  endfunction
  function automatic logic [PW-1:0] inc(logic [PW-1:0] x);
    return x == PW'(N - 1) ? '0 : x + 1'b1;
  endfunction
  // descending scan so the valid requester closest to ptr wins
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (bus.in_valid[wrap(int'(ptr_q) + k)]) begin
        sel   = wrap(int'(ptr_q) + k);
        found = 1'b1;
      end
    end
  end
  always_comb begin
    adv          = ~out_valid_q | bus.out_ready;
    cur          = (state_q == LOCKED) ? owner_q : sel;
    acc          = adv & bus.in_valid[cur];
    cur_last     = bus.in_last[cur];
    bus.in_ready = (nreset & adv & ((state_q == LOCKED) | found)) ? N'(1) << cur : '0;
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    grant_d      = grant_q;
    pkt_count_d  = pkt_count_q + {31'd0, acc & cur_last};
    out_valid_d  = adv ? acc : out_valid_q;
    out_data_d   = acc ? bus.in_data[int'(cur)*DW +: DW] : out_data_q;
    out_dest_d   = acc ? bus.in_dest[int'(cur)*32 +: 32] : out_dest_q;
    out_last_d   = acc ? cur_last : out_last_q;
    if (acc && cur_last) begin
      state_d = IDLE;
      grant_d = '0;
      ptr_d   = inc(cur);
    end else if (acc && state_q == IDLE) begin
      state_d = LOCKED;
      grant_d = N'(1) << sel;
      owner_d = sel;
    end
  end
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      grant_q     <= '0;
      pkt_count_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_dest_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      grant_q     <= grant_d;
      pkt_count_q <= pkt_count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_dest_q  <= out_dest_d;
      out_last_q  <= out_last_d;
    end
  end
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_dest  = out_dest_q;
  assign bus.out_last  = out_last_q;
  assign grant         = grant_q;
  assign pkt_count     = pkt_count_q;
endmodule
